// File: rtl/backward_ext_pipe.sv
// Backward BWT-extension datapath: two register stages computing all four
// backward extensions of an SMEM interval, with valid/ready flow control.
module backward_ext_pipe #(
    parameter int IDX_W = 64,
    parameter int POS_W = 7,
    parameter int CTX_W = 128,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CTX_W-1:0]     in_ctx,
    input  logic [IDX_W-1:0]     ik_x0,
    input  logic [IDX_W-1:0]     ik_x1,
    input  logic [IDX_W-1:0]     ik_x2,
    input  logic [4*IDX_W-1:0]   occ_k,
    input  logic [4*IDX_W-1:0]   occ_l,
    input  logic [4*IDX_W-1:0]   l2,
    input  logic [IDX_W-1:0]     primary,
    input  logic [2:0]           base_c,
    input  logic [POS_W-1:0]     min_intv,
    input  logic                 drain,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CTX_W-1:0]     out_ctx,
    output logic [12*IDX_W-1:0]  ok_all,
    output logic [IDX_W-1:0]     ok_sel_x0,
    output logic [IDX_W-1:0]     ok_sel_x1,
    output logic [IDX_W-1:0]     ok_sel_x2,
    output logic                 keep,
    output logic                 changed,
    output logic                 idle,
    output logic [CNT_W-1:0]     stat_in,
    output logic [CNT_W-1:0]     stat_keep
);

    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                adv1_s, adv2_s;
    logic                s1_v_q, s2_v_q;
    logic [CTX_W-1:0]    s1_ctx_q, s2_ctx_q;
    logic [4*IDX_W-1:0]  s1_x0_q, s1_x2_q, s1_x0_d, s1_x2_d;
    logic [IDX_W-1:0]    s1_ik_x1_q, s1_ik_x2_q;
    logic                s1_pbit_q, s1_pbit_d;
    logic [2:0]          s1_base_q;
    logic [POS_W-1:0]    s1_min_q;

    logic [12*IDX_W-1:0] ok_all_q, ok_all_d;
    logic [IDX_W-1:0]    sel_x0_q, sel_x1_q, sel_x2_q;
    logic [IDX_W-1:0]    sel_x0_d, sel_x1_d, sel_x2_d;
    logic                keep_q, keep_d, changed_q, changed_d;
    logic [IDX_W-1:0]    x1_s [4];
    logic [CNT_W-1:0]    stat_in_q, stat_keep_q;

    assign adv2_s   = !s2_v_q || out_ready;
    assign adv1_s   = !s1_v_q || adv2_s;
    assign in_ready = adv1_s;

    // Stage-1 arithmetic: per-base x0/x2 and the primary-in-interval bit.
    always_comb begin
        s1_x0_d = {(4*IDX_W){1'b0}};
        s1_x2_d = {(4*IDX_W){1'b0}};
        for (int c = 0; c < 4; c++) begin
            s1_x0_d[c*IDX_W +: IDX_W] = l2[c*IDX_W +: IDX_W] + occ_k[c*IDX_W +: IDX_W] + IDX_ONE;
            s1_x2_d[c*IDX_W +: IDX_W] = occ_l[c*IDX_W +: IDX_W] - occ_k[c*IDX_W +: IDX_W];
        end
        s1_pbit_d = (ik_x2 != IDX_ZERO) && (ik_x0 <= primary) &&
                    (primary <= (ik_x0 + ik_x2 - IDX_ONE));
    end

    // Stage-1 register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q     <= 1'b0;
            s1_ctx_q   <= {CTX_W{1'b0}};
            s1_x0_q    <= {(4*IDX_W){1'b0}};
            s1_x2_q    <= {(4*IDX_W){1'b0}};
            s1_ik_x1_q <= IDX_ZERO;
            s1_ik_x2_q <= IDX_ZERO;
            s1_pbit_q  <= 1'b0;
            s1_base_q  <= 3'd0;
            s1_min_q   <= {POS_W{1'b0}};
        end else begin
            if (adv1_s) begin
                s1_v_q <= in_valid;
            end
            if (adv1_s && in_valid) begin
                s1_ctx_q   <= in_ctx;
                s1_x0_q    <= s1_x0_d;
                s1_x2_q    <= s1_x2_d;
                s1_ik_x1_q <= ik_x1;
                s1_ik_x2_q <= ik_x2;
                s1_pbit_q  <= s1_pbit_d;
                s1_base_q  <= base_c;
                s1_min_q   <= min_intv;
            end
        end
    end

    // Stage-2 arithmetic: x1 chain runs from base 3 down to base 0, then select.
    always_comb begin
        x1_s[3] = s1_ik_x1_q + {{(IDX_W-1){1'b0}}, s1_pbit_q};
        for (int c = 2; c >= 0; c--) begin
            x1_s[c] = x1_s[c+1] + s1_x2_q[(c+1)*IDX_W +: IDX_W];
        end
        ok_all_d = {(12*IDX_W){1'b0}};
        for (int c = 0; c < 4; c++) begin
            ok_all_d[(3*c)*IDX_W   +: IDX_W] = s1_x0_q[c*IDX_W +: IDX_W];
            ok_all_d[(3*c+1)*IDX_W +: IDX_W] = x1_s[c];
            ok_all_d[(3*c+2)*IDX_W +: IDX_W] = s1_x2_q[c*IDX_W +: IDX_W];
        end
        case (s1_base_q)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                sel_x0_d = s1_x0_q[s1_base_q[1:0]*IDX_W +: IDX_W];
                sel_x1_d = x1_s[s1_base_q[1:0]];
                sel_x2_d = s1_x2_q[s1_base_q[1:0]*IDX_W +: IDX_W];
            end
            default: begin
                sel_x0_d = IDX_ZERO;
                sel_x1_d = IDX_ZERO;
                sel_x2_d = IDX_ZERO;
            end
        endcase
        keep_d    = (s1_base_q <= 3'd3) && (sel_x2_d >= {{(IDX_W-POS_W){1'b0}}, s1_min_q});
        changed_d = (sel_x2_d != s1_ik_x2_q);
    end

    // Stage-2 register; drives the block outputs directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v_q    <= 1'b0;
            s2_ctx_q  <= {CTX_W{1'b0}};
            ok_all_q  <= {(12*IDX_W){1'b0}};
            sel_x0_q  <= IDX_ZERO;
            sel_x1_q  <= IDX_ZERO;
            sel_x2_q  <= IDX_ZERO;
            keep_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            if (adv2_s) begin
                s2_v_q <= s1_v_q;
            end
            if (adv2_s && s1_v_q) begin
                s2_ctx_q  <= s1_ctx_q;
                ok_all_q  <= ok_all_d;
                sel_x0_q  <= sel_x0_d;
                sel_x1_q  <= sel_x1_d;
                sel_x2_q  <= sel_x2_d;
                keep_q    <= keep_d;
                changed_q <= changed_d;
            end
        end
    end

    // Saturating transfer counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_in_q   <= {CNT_W{1'b0}};
            stat_keep_q <= {CNT_W{1'b0}};
        end else begin
            if (in_valid && adv1_s && (stat_in_q != {CNT_W{1'b1}})) begin
                stat_in_q <= stat_in_q + CNT_ONE;
            end
            if (s2_v_q && out_ready && keep_q && (stat_keep_q != {CNT_W{1'b1}})) begin
                stat_keep_q <= stat_keep_q + CNT_ONE;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_ctx   = s2_ctx_q;
    assign ok_all    = ok_all_q;
    assign ok_sel_x0 = sel_x0_q;
    assign ok_sel_x1 = sel_x1_q;
    assign ok_sel_x2 = sel_x2_q;
    assign keep      = keep_q;
    assign changed   = changed_q;
    assign stat_in   = stat_in_q;
    assign stat_keep = stat_keep_q;
    // Held low during reset so a drain request never reports idle before the pipe exists.
    assign idle      = rst && drain && !s1_v_q && !s2_v_q;

endmodule
